// File: rtl/writeback_stage.sv
// Writeback pipeline register: selects ALU or load data and drives the register-file write port.
// Define WB_SUBWORD_LOAD_EN to compile in half/byte load extraction; otherwise loads pass the raw word.
module writeback_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic              mem_memtoreg,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic [1:0]        mem_load_size,
    input  logic              mem_load_unsigned,
    input  logic [1:0]        mem_byte_offset,
    output logic              rfw_enable,
    output logic [ADDR_W-1:0] rfw_address3,
    output logic [DATA_W-1:0] rfw_data3,
    output logic              wb_valid
);

    // Flow control: flush beats stall; a flush loads a bubble, a stall freezes the
    // register, and otherwise the MEM inputs are captured every cycle.
    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] next_data;
    logic              next_enable;

`ifdef WB_SUBWORD_LOAD_EN
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = mem_byte_offset[1] ? mem_load_data[31:16] : mem_load_data[15:0];
        case (mem_byte_offset)
            2'd0:    byte_sel = mem_load_data[7:0];
            2'd1:    byte_sel = mem_load_data[15:8];
            2'd2:    byte_sel = mem_load_data[23:16];
            default: byte_sel = mem_load_data[31:24];
        endcase
        // Size 11 is treated as a word, same as 00.
        case (mem_load_size)
            2'b01:   load_value = {{(DATA_W-16){half_sel[15] & ~mem_load_unsigned}}, half_sel};
            2'b10:   load_value = {{(DATA_W-8){byte_sel[7] & ~mem_load_unsigned}}, byte_sel};
            default: load_value = mem_load_data;
        endcase
    end
`else
    logic unused_subword;

    assign load_value     = mem_load_data;
    assign unused_subword = ^{mem_load_size, mem_load_unsigned, mem_byte_offset};
`endif

    assign next_data   = mem_memtoreg ? load_value : mem_alu_result;
    assign next_enable = mem_valid & mem_regwrite & (mem_dest != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid     <= 1'b0;
            rfw_enable   <= 1'b0;
            rfw_address3 <= '0;
            rfw_data3    <= '0;
        end else if (flush) begin
            // Address/data are left as-is; they are meaningless once enable drops.
            wb_valid   <= 1'b0;
            rfw_enable <= 1'b0;
        end else if (!stall) begin
            wb_valid     <= mem_valid;
            rfw_enable   <= next_enable;
            rfw_address3 <= mem_dest;
            rfw_data3    <= next_data;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus a randomized run against a reference model.
// Expectations follow WB_SUBWORD_LOAD_EN the same way the design build does.
module tb_writeback_stage;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int OBS_W  = DATA_W + ADDR_W + 2;

  logic              clk;
  logic              reset_n;
  logic              stall;
  logic              flush;
  logic              mem_valid;
  logic              mem_regwrite;
  logic              mem_memtoreg;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_load_data;
  logic [1:0]        mem_load_size;
  logic              mem_load_unsigned;
  logic [1:0]        mem_byte_offset;
  logic              rfw_enable;
  logic [ADDR_W-1:0] rfw_address3;
  logic [DATA_W-1:0] rfw_data3;
  logic              wb_valid;

  int tests_run;
  int tests_failed;

  logic [OBS_W-1:0] exp_q[$];

  writeback_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .stall             (stall),
    .flush             (flush),
    .mem_valid         (mem_valid),
    .mem_regwrite      (mem_regwrite),
    .mem_memtoreg      (mem_memtoreg),
    .mem_dest          (mem_dest),
    .mem_alu_result    (mem_alu_result),
    .mem_load_data     (mem_load_data),
    .mem_load_size     (mem_load_size),
    .mem_load_unsigned (mem_load_unsigned),
    .mem_byte_offset   (mem_byte_offset),
    .rfw_enable        (rfw_enable),
    .rfw_address3      (rfw_address3),
    .rfw_data3         (rfw_data3),
    .wb_valid          (wb_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver
  task automatic drive_mem(input logic v, input logic rw, input logic mtr, input logic [ADDR_W-1:0] dest,
                           input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] ld, input logic [1:0] size,
                           input logic uns, input logic [1:0] off);
    mem_valid         = v;
    mem_regwrite      = rw;
    mem_memtoreg      = mtr;
    mem_dest          = dest;
    mem_alu_result    = alu;
    mem_load_data     = ld;
    mem_load_size     = size;
    mem_load_unsigned = uns;
    mem_byte_offset   = off;
  endtask

  // reference: value written back for a captured instruction
  function automatic logic [DATA_W-1:0] ref_wdata(input logic mtr, input logic [DATA_W-1:0] alu,
                                                  input logic [DATA_W-1:0] ld, input logic [1:0] size,
                                                  input logic uns, input logic [1:0] off);
    logic [DATA_W-1:0] v;
    if (!mtr) return alu;
    v = ld;
`ifdef WB_SUBWORD_LOAD_EN
    if (size == 2'b01) begin
      v = (ld >> (16 * int'(off / 2))) & 32'h0000_FFFF;
      if (!uns && v >= 32'h0000_8000) v = v + 32'hFFFF_0000;
    end else if (size == 2'b10) begin
      v = (ld >> (8 * int'(off))) & 32'h0000_00FF;
      if (!uns && v >= 32'h0000_0080) v = v + 32'hFFFF_FF00;
    end
`endif
    return v;
  endfunction

  task automatic test_reset();
    logic [OBS_W-1:0] obs;
    reset_n = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    drive_mem(1'b1, 1'b1, 1'b0, 5'd9, 32'hDEAD_BEEF, 32'h0, 2'b00, 1'b0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    obs = {wb_valid, rfw_enable, rfw_address3, rfw_data3};
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("FAIL reset_held: got %h expected 0", obs);
    end
    stall   = 1'b1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    obs = {wb_valid, rfw_enable, rfw_address3, rfw_data3};
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("FAIL reset_release_stalled: got %h expected 0", obs);
    end
    stall = 1'b0;
    @(posedge clk);
    #1;
    obs = {wb_valid, rfw_enable, rfw_address3, rfw_data3};
    tests_run++;
    if (obs !== {1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF}) begin
      tests_failed++;
      $display("FAIL reset_first_capture: got %h expected %h", obs, {1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF});
    end
    // asynchronous assertion between edges while stalled
    stall = 1'b1;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    obs = {wb_valid, rfw_enable, rfw_address3, rfw_data3};
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: got %h expected 0", obs);
    end
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    obs = {wb_valid, rfw_enable, rfw_address3, rfw_data3};
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("FAIL reset_discard_stalled: got %h expected 0", obs);
    end
    stall = 1'b0;
  endtask

  task automatic test_alu_write();
    logic [OBS_W-1:0] obs;
    drive_mem(1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_1234, 32'hFFFF_FFFF, 2'b10, 1'b0, 2'b01);
    @(posedge clk);
    #1;
    obs = {wb_valid, rfw_enable, rfw_address3, rfw_data3};
    tests_run++;
    if (obs !== {1'b1, 1'b1, 5'd8, 32'h0000_1234}) begin
      tests_failed++;
      $display("FAIL alu_write: got %h expected %h", obs, {1'b1, 1'b1, 5'd8, 32'h0000_1234});
    end
  endtask

  task automatic test_reg0();
    drive_mem(1'b1, 1'b1, 1'b0, 5'd0, 32'h5555_AAAA, 32'h0, 2'b00, 1'b0, 2'b00);
    @(posedge clk);
    #1;
    tests_run++;
    if ({wb_valid, rfw_enable} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reg0_suppress: got valid/en %b expected 10", {wb_valid, rfw_enable});
    end
  endtask

  task automatic test_load();
    logic [1:0]        size_t[4];
    logic [1:0]        off_t[4];
    logic              uns_t[4];
    logic [DATA_W-1:0] exp_t[4];
`ifdef WB_SUBWORD_LOAD_EN
    size_t = '{2'b10, 2'b10, 2'b01, 2'b01};
    off_t  = '{2'd0, 2'd1, 2'd2, 2'd3};
    uns_t  = '{1'b0, 1'b1, 1'b0, 1'b0};
    exp_t  = '{32'hFFFF_FF85, 32'h0000_007F, 32'hFFFF_80F0, 32'hFFFF_80F0};
`else
    size_t = '{2'b10, 2'b10, 2'b01, 2'b00};
    off_t  = '{2'd0, 2'd1, 2'd2, 2'd3};
    uns_t  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_t  = '{32'h80F0_7F85, 32'h80F0_7F85, 32'h80F0_7F85, 32'h80F0_7F85};
`endif
    for (int i = 0; i < 4; i++) begin
      drive_mem(1'b1, 1'b1, 1'b1, 5'(i + 1), 32'h1111_1111, 32'h80F0_7F85, size_t[i], uns_t[i], off_t[i]);
      @(posedge clk);
      #1;
      tests_run++;
      if (rfw_data3 !== exp_t[i] || rfw_enable !== 1'b1) begin
        tests_failed++;
        $display("FAIL load_case%0d: got en=%b data=%h expected en=1 data=%h", i, rfw_enable, rfw_data3, exp_t[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    logic [OBS_W-1:0] held;
    logic [OBS_W-1:0] obs;
    drive_mem(1'b1, 1'b1, 1'b0, 5'd3, 32'h0000_CAFE, 32'h0, 2'b00, 1'b0, 2'b00);
    @(posedge clk);
    #1;
    held = {1'b1, 1'b1, 5'd3, 32'h0000_CAFE};
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_mem(1'b1, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(4, 31)), $urandom, $urandom,
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      @(posedge clk);
      #1;
      obs = {wb_valid, rfw_enable, rfw_address3, rfw_data3};
      tests_run++;
      if (obs !== held) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: got %h expected %h", i, obs, held);
      end
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({wb_valid, rfw_enable} !== 2'b00) begin
      tests_failed++;
      $display("FAIL flush_over_stall: got valid/en %b expected 00", {wb_valid, rfw_enable});
    end
    flush = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_random();
    logic              m_valid;
    logic              m_en;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic [OBS_W-1:0]  exp_v;
    m_valid = 1'b0;
    m_en    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    for (int c = 0; c < 400; c++) begin
      stall = (c == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
      flush = (c == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
      drive_mem(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom,
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      if (flush) begin
        m_valid = 1'b0;
        m_en    = 1'b0;
      end else if (!stall) begin
        m_valid = mem_valid;
        m_en    = mem_valid && mem_regwrite && (mem_dest != 0);
        m_addr  = mem_dest;
        m_data  = ref_wdata(mem_memtoreg, mem_alu_result, mem_load_data, mem_load_size,
                            mem_load_unsigned, mem_byte_offset);
      end
      exp_q.push_back({m_valid, m_en, m_addr, m_data});
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      tests_run++;
      if ({wb_valid, rfw_enable} !== exp_v[OBS_W-1 -: 2] ||
          (exp_v[OBS_W-2] && {rfw_address3, rfw_data3} !== exp_v[DATA_W+ADDR_W-1:0])) begin
        tests_failed++;
        $display("FAIL random_cycle%0d: got %h expected %h", c,
                 {wb_valid, rfw_enable, rfw_address3, rfw_data3}, exp_v);
      end
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_alu_write();
    test_reg0();
    test_load();
    test_stall_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
